// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the parametrised serial sequence detector.
// Optional match counter is enabled by defining SEQDET_MATCH_CNT_EN.
package seq_det_pkg;

    localparam logic SEQ_NONOVERLAP = 1'b0;
    localparam logic SEQ_OVERLAP    = 1'b1;

    // Width needed to hold any length from 0 to max_len inclusive.
    function automatic int calc_len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
        int unsigned res;
        if (len == 32'd0) begin
            res = 32'd1;
        end else if (len > max_len) begin
            res = max_len;
        end else begin
            res = len;
        end
        return res;
    endfunction

endpackage

// File: rtl/seq_det_match_cnt.sv
// Saturating match counter with synchronous clear; instantiated only when
// SEQDET_MATCH_CNT_EN is defined.
module seq_det_match_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_cnt;

    // Clear beats increment; increment stops at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (i_clr) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (i_inc && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/seq_detector_param.sv
// Moore serial bit-sequence detector with runtime pattern, length and overlap mode.
// Define SEQDET_MATCH_CNT_EN to build the saturating match counter.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = calc_len_w(MAX_LEN),
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_en,
    input  logic               i_x,
    input  logic               i_load,
    input  logic [MAX_LEN-1:0] i_pattern,
    input  logic [LEN_W-1:0]   i_len,
    input  logic               i_overlap,
    input  logic               i_cnt_clr,
    output logic               o_y,
    output logic [CNT_W-1:0]   o_match_cnt
);

    localparam logic [LEN_W-1:0] MAX_FILL = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0] r_cfg_pat;
    logic [LEN_W-1:0]   r_cfg_len;
    logic               r_cfg_ovl;
    logic [MAX_LEN-1:0] r_hist;
    logic [LEN_W-1:0]   r_fill;
    logic               r_y;

    logic [MAX_LEN-1:0] w_mask;
    logic [MAX_LEN-1:0] w_nhist;
    logic [LEN_W-1:0]   w_nfill;
    logic [LEN_W-1:0]   w_len_cap;
    logic               w_hit;

    // Low cfg_len bits of the window take part in the compare.
    always_comb begin
        w_mask = {MAX_LEN{1'b0}};
        for (int i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (LEN_W'(i) < r_cfg_len);
        end
    end

    generate
        if (MAX_LEN > 1) begin : g_shift
            assign w_nhist = {r_hist[MAX_LEN-2:0], i_x};
        end else begin : g_single
            assign w_nhist = i_x;
        end
    endgenerate

    assign w_nfill   = (r_fill == MAX_FILL) ? r_fill : (r_fill + {{(LEN_W-1){1'b0}}, 1'b1});
    assign w_hit     = (w_nfill >= r_cfg_len) && ((w_nhist & w_mask) == (r_cfg_pat & w_mask));
    assign w_len_cap = LEN_W'(clamp_len(32'(i_len), 32'(MAX_LEN)));

    // Config capture, history shift and registered detect pulse; load outranks en.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cfg_pat <= {MAX_LEN{1'b0}};
            r_cfg_len <= MAX_FILL;
            r_cfg_ovl <= SEQ_NONOVERLAP;
            r_hist    <= {MAX_LEN{1'b0}};
            r_fill    <= {LEN_W{1'b0}};
            r_y       <= 1'b0;
        end else if (i_load) begin
            r_cfg_pat <= i_pattern;
            r_cfg_len <= w_len_cap;
            r_cfg_ovl <= i_overlap;
            r_fill    <= {LEN_W{1'b0}};
            r_y       <= 1'b0;
        end else if (i_en) begin
            r_hist <= w_nhist;
            r_y    <= w_hit;
            // Non-overlap restarts the fill so no bit of a match is reused.
            if (w_hit && (r_cfg_ovl == SEQ_NONOVERLAP)) begin
                r_fill <= {LEN_W{1'b0}};
            end else begin
                r_fill <= w_nfill;
            end
        end else begin
            r_y <= 1'b0;
        end
    end

    assign o_y = r_y;

`ifdef SEQDET_MATCH_CNT_EN
    logic w_cnt_inc;
    logic w_cnt_clr;

    assign w_cnt_inc = i_en & ~i_load & w_hit;
    assign w_cnt_clr = i_cnt_clr | i_load;

    seq_det_match_cnt #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_cnt_clr),
        .i_inc (w_cnt_inc),
        .o_cnt (o_match_cnt)
    );
`else
    logic w_unused_cnt_clr;

    assign w_unused_cnt_clr = i_cnt_clr;
    assign o_match_cnt      = {CNT_W{1'b0}};
`endif

endmodule
